// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: data_mem length encodings, RISC-V load/store
// exception cause codes and the access-size helper.
package mem_pkg;

  typedef enum logic [2:0] {
    LEN_B  = 3'd0,
    LEN_H  = 3'd1,
    LEN_W  = 3'd2,
    LEN_BU = 3'd3,
    LEN_HU = 3'd4
  } mem_len_e;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  // Byte count of an access; illegal encodings fall to 4 and are caught separately.
  function automatic logic [2:0] len_size(input logic [2:0] len);
    case (len)
      3'd0, 3'd3: len_size = 3'd1;
      3'd1, 3'd4: len_size = 3'd2;
      3'd2:       len_size = 3'd4;
      default:    len_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational range/alignment/legality check for a data access, producing
// the matching RISC-V exception cause. Stateless so it can be shared with fetch.
module mem_access_check
  import mem_pkg::*;
#(
  parameter int MEM_BYTES     = 256,
  parameter bit MISALIGN_TRAP = 1'b0
) (
  input  logic [31:0] addr,
  input  logic [2:0]  len,
  input  logic        is_load,
  input  logic        is_store,
  output logic        illegal,
  output logic        range_fault,
  output logic        misalign,
  output logic [3:0]  cause
);

  logic [2:0]  size_s;
  logic [32:0] end_addr_s;
  logic        is_mem_s;
  logic        unaligned_s;
  logic        access_fault_s;

  // End address is formed at 33 bits so accesses near 2^32 cannot wrap into range.
  always_comb begin
    is_mem_s    = is_load | is_store;
    size_s      = len_size(len);
    end_addr_s  = {1'b0, addr} + {30'd0, size_s} - 33'd1;
    illegal     = is_mem_s & (len > 3'd4);
    range_fault = is_mem_s & (end_addr_s >= 33'(MEM_BYTES));
    case (size_s)
      3'd2:    unaligned_s = addr[0];
      3'd4:    unaligned_s = (addr[1:0] != 2'b00);
      default: unaligned_s = 1'b0;
    endcase
    misalign       = MISALIGN_TRAP & is_mem_s & unaligned_s;
    access_fault_s = illegal | range_fault;
    // A request flagged as both load and store is reported as a store.
    if (!(access_fault_s | misalign)) begin
      cause = 4'd0;
    end else if (is_store) begin
      cause = access_fault_s ? CAUSE_ST_FAULT : CAUSE_ST_MISALIGN;
    end else begin
      cause = access_fault_s ? CAUSE_LD_FAULT : CAUSE_LD_MISALIGN;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// MEM-stage controller: drives data_mem from the EX/MEM request, traps bad
// accesses and presents the MEM/WB result with valid/ready backpressure.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_BYTES     = 256,
  parameter int ADDR_W        = $clog2(MEM_BYTES),
  parameter bit MISALIGN_TRAP = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_mem_len,
  input  logic              flush,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_in,
  output logic [2:0]        dm_len,
  output logic              dm_read,
  output logic              dm_write,
  input  logic [31:0]       dm_out,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [31:0]       wb_data,
  output logic              wb_exc,
  output logic [3:0]        wb_cause,
  output logic [31:0]       wb_badaddr
);

  logic        accept_s;
  logic        fault_s;
  logic        illegal_s;
  logic        range_fault_s;
  logic        misalign_s;
  logic [3:0]  cause_s;
  logic        is_load_r;
  logic [31:0] alu_result_r;

  mem_access_check #(
    .MEM_BYTES     (MEM_BYTES),
    .MISALIGN_TRAP (MISALIGN_TRAP)
  ) u_check (
    .addr        (ex_alu_result),
    .len         (ex_mem_len),
    .is_load     (ex_mem_read),
    .is_store    (ex_mem_write),
    .illegal     (illegal_s),
    .range_fault (range_fault_s),
    .misalign    (misalign_s),
    .cause       (cause_s)
  );

  // Handshake and data_mem strobes; strobes only fire on an accept so dm_out freezes under stall.
  always_comb begin
    ex_ready = !wb_valid | wb_ready;
    accept_s = ex_valid & ex_ready & !flush;
    fault_s  = illegal_s | range_fault_s | misalign_s;
    dm_read  = accept_s & ex_mem_read & !fault_s;
    dm_write = accept_s & ex_mem_write & !fault_s;
    dm_addr  = ex_alu_result[ADDR_W-1:0];
    dm_in    = ex_store_data;
    dm_len   = ex_mem_len;
    wb_data  = (is_load_r & !wb_exc) ? dm_out : alu_result_r;
  end

  // MEM/WB result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
      wb_exc       <= 1'b0;
      wb_cause     <= 4'd0;
      wb_badaddr   <= 32'd0;
      is_load_r    <= 1'b0;
      alu_result_r <= 32'd0;
    end else if (accept_s) begin
      wb_valid     <= 1'b1;
      wb_rd        <= ex_rd;
      wb_reg_write <= ex_reg_write & !fault_s;
      wb_exc       <= fault_s;
      wb_cause     <= cause_s;
      wb_badaddr   <= fault_s ? ex_alu_result : 32'd0;
      is_load_r    <= ex_mem_read & !ex_mem_write;
      alu_result_r <= ex_alu_result;
    end else if (wb_ready | flush) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Control stage of the MEM stage. Sits between the EX/MEM pipeline register and data_mem, and produces the MEM/WB result.
- Accepts one EX request per cycle over a valid/ready handshake and drives data_mem control signals. Checks range and alignment, and raises load/store exceptions with RISC-V cause codes.
- Tracks data_mem's 1-cycle registered read latency and selects between load data and ALU result for writeback. Holds output stable under backpressure.

Parameters:
- MEM_BYTES, 256, byte capacity of data_mem (byte addresses 0..MEM_BYTES-1).
- ADDR_W, $clog2(MEM_BYTES), width of the data_mem byte address.
- MISALIGN_TRAP, 0, 1 = misaligned half/word accesses trap; 0 = passed to data_mem unchanged.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX request valid.
- ex_ready  out  1  stage can accept a request this cycle.
- ex_alu_result  in  32  effective address (mem ops) or ALU result.
- ex_store_data  in  32  rs2 store data.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  instruction writes rd.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_mem_len  in  3  0=B, 1=H, 2=W, 3=BU, 4=HU; 5-7 illegal.
- flush  in  1  kill the request presented this cycle and the WB output.
- dm_addr  out  ADDR_W  to data_mem addr.
- dm_in  out  32  to data_mem in.
- dm_len  out  3  to data_mem MemLen.
- dm_read  out  1  to data_mem MemRead.
- dm_write  out  1  to data_mem MemWrite.
- dm_out  in  32  from data_mem out; valid the cycle after dm_read.
- wb_valid  out  1  WB result valid.
- wb_ready  in  1  WB accepts the result.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  write enable; forced 0 on exception.
- wb_data  out  32  load data or ALU result.
- wb_exc  out  1  exception on this result.
- wb_cause  out  4  4 = load misaligned, 5 = load fault, 6 = store misaligned, 7 = store fault.
- wb_badaddr  out  32  faulting effective address.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high. On reset: wb_valid, wb_reg_write, wb_exc = 0; wb_rd, wb_cause, wb_badaddr, internal data register = 0. A reset during an access drops it; a store already sampled by data_mem is not undone.
- Handshake:
  - ex_ready = !wb_valid | wb_ready.
  - An accept occurs when ex_valid & ex_ready & !flush.
- Access size:
  - size = 1 for B/BU, 2 for H/HU, 4 for W.
  - illegal = ex_mem_len > 4 on a load or store.
- Fault checks, in priority order:
  - Access fault: illegal, or ex_alu_result + size - 1 >= MEM_BYTES. Computed at 33-bit width, so no wrap at 2^32.
  - Misaligned fault: MISALIGN_TRAP = 1 and ex_alu_result not a multiple of size.
- data_mem drive (combinational in the accept cycle):
  - dm_read = accept & ex_mem_read & !fault.
  - dm_write = accept & ex_mem_write & !fault.
  - dm_addr = ex_alu_result[ADDR_W-1:0], dm_in = ex_store_data, dm_len = ex_mem_len.
  - Neither strobe is ever asserted while not accepting. This keeps dm_out frozen during backpressure.
- Registration on the accept edge:
  - wb_valid <= 1.
  - wb_rd, is_load, alu_result are registered.
  - wb_reg_write <= ex_reg_write & !fault.
  - wb_exc, wb_cause, wb_badaddr are registered.
- Accept-free edge: if wb_ready, or flush, then wb_valid <= 0.
- Output mux: wb_data = (is_load & !wb_exc) ? dm_out : alu_result.
- Latency: 1 cycle. Throughput: 1 per cycle.
- Back-to-back store then load to the same address gives the new data, because the store completes at the edge before the load's read edge.
- Ordering: a load and a store both asserted on one request are treated as a store (cause 6/7). Such a request does not occur in legal decode.
- Flush:
  - Suppresses dm_read and dm_write this cycle.
  - Clears wb_valid next edge, even if wb_ready = 0.
  - flush takes priority over ex_valid.
- Backpressure: while wb_valid & !wb_ready, all wb_* outputs are held stable and no data_mem access is issued.

Decomposition:
- Shared package mem_pkg holds:
  - MemLen encodings: LEN_B=0, LEN_H=1, LEN_W=2, LEN_BU=3, LEN_HU=4.
  - Cause constants: CAUSE_LD_MISALIGN=4, CAUSE_LD_FAULT=5, CAUSE_ST_MISALIGN=6, CAUSE_ST_FAULT=7.
- One natural sub-module: mem_access_check. It is combinational, computes size, illegal, range fault, misalign and cause, and is reusable by a future instruction-fetch check.

Test Plan:
- Reset state: hold rst 2 cycles -> wb_valid=0, ex_ready=1, dm_read=0, dm_write=0.
- Initialised memory (byte a holds a): LW 0x10 -> next cycle wb_data=0x13121110, wb_reg_write=1. LB 0x80 -> 0xFFFFFF80. LBU 0x80 -> 0x00000080. LHU 0x41 -> 0x00004241.
- SW 0xDEADBEEF @0x20, then LW 0x20 in the next cycle -> wb_data=0xDEADBEEF. Store result has wb_reg_write=0.
- Fault: LW @0xFE -> dm_read stays 0, wb_exc=1, wb_cause=5, wb_badaddr=0xFE, wb_reg_write=0. With MISALIGN_TRAP=1, SH @0x03 -> wb_cause=6 and dm_write stays 0. ex_mem_len=6 on a load -> cause 5.
- Backpressure: LW 0x10 then LW 0x14, with wb_ready=0 for 3 cycles -> ex_ready=0, wb_data held at 0x13121110, dm_read=0. When wb_ready rises, the second load issues and gives 0x17161514.
- Flush: SW 0x55 @0x30 with flush=1 -> dm_write=0, wb_valid=0 next cycle. A later LBU 0x30 returns 0x30.
